desplazador_secuencial: RTL and testbench

//  Multi-cycle ARM shifter: LSL/LSR/ASR/ROR of an N-bit operand, one bit position per clock.

---
 rtl/desplazador_secuencial_if.sv | 27 ++
 rtl/desplazador_secuencial.sv | 142 ++++++++++++++
 tb/tb_desplazador_secuencial.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/desplazador_secuencial_if.sv
// Purpose: start/busy/done request bundle between the control FSM and the sequential shifter.
// Latency: none, wires only.
// Backpressure: the requester holds start until busy is low; the shifter ignores start while busy.
interface desplazador_secuencial_if #(
  parameter int N  = 32,
  parameter int AW = 8
);
  logic          start;
  logic [1:0]    op;
  logic [N-1:0]  a;
  logic [AW-1:0] amount;
  logic          carry_in;
  logic [N-1:0]  result;
  logic          carry_out;
  logic          busy;
  logic          done;

  modport master (
    output start, op, a, amount, carry_in,
    input  result, carry_out, busy, done
  );

  modport slave (
    input  start, op, a, amount, carry_in,
    output result, carry_out, busy, done
  );
endinterface

// File: rtl/desplazador_secuencial.sv
// Purpose: ARM LSL/LSR/ASR/ROR shifter with carry-out, one bit position per clock.
// Latency: done pulses k+1 cycles after accept (k = min(amount,N), or amount mod N for ROR).
// Backpressure: start is only accepted in IDLE; requests during SHIFT/DONE are dropped.
module desplazador_secuencial #(
  parameter int N  = 32,
  parameter int AW = 8
) (
  input logic                    clk,
  input logic                    rst_n,
  desplazador_secuencial_if.slave bus
);

  localparam int SW = $clog2(N);
  localparam int CW = SW + 1;

  localparam logic [1:0] OP_LSL = 2'b00;
  localparam logic [1:0] OP_LSR = 2'b01;
  localparam logic [1:0] OP_ASR = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t        state;
  logic [N-1:0]  w;
  logic [1:0]    op_q;
  logic [CW-1:0] cnt;
  logic          kill_c;

  logic [31:0]   amt_ext;
  logic [CW-1:0] k;
  logic          init_c;
  logic          kill_nxt;
  logic [N-1:0]  w_nxt;
  logic          c_nxt;

  // Decode the request: iteration count, carry to report when no shift happens,
  // and whether an over-range LSL/LSR must force the carry to zero.
  always_comb begin
    amt_ext  = 32'(bus.amount);
    k        = '0;
    init_c   = bus.carry_in;
    kill_nxt = 1'b0;
    if (bus.op == OP_ROR) begin
      k = CW'(amt_ext & 32'(N - 1));
      // Non-zero multiple of N: full rotations leave a unchanged, carry is the MSB.
      if ((amt_ext != 32'd0) && (k == '0)) begin
        init_c = bus.a[N-1];
      end
    end else if (amt_ext > 32'(N)) begin
      k        = CW'(N);
      // ASR saturates naturally to sign copies; LSL/LSR past N must report carry 0.
      kill_nxt = (bus.op != OP_ASR);
    end else begin
      k = CW'(amt_ext);
    end
  end

  // One-position shift of the working register and the bit it pushes out.
  always_comb begin
    w_nxt = w;
    c_nxt = 1'b0;
    case (op_q)
      OP_LSL: begin
        c_nxt = w[N-1];
        w_nxt = {w[N-2:0], 1'b0};
      end
      OP_LSR: begin
        c_nxt = w[0];
        w_nxt = {1'b0, w[N-1:1]};
      end
      OP_ASR: begin
        c_nxt = w[0];
        w_nxt = {w[N-1], w[N-1:1]};
      end
      default: begin
        c_nxt = w[0];
        w_nxt = {w[0], w[N-1:1]};
      end
    endcase
  end

  // Control FSM with registered outputs; result/carry_out load only when entering DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      w             <= '0;
      op_q          <= OP_LSL;
      cnt           <= '0;
      kill_c        <= 1'b0;
      bus.result    <= '0;
      bus.carry_out <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            op_q     <= bus.op;
            w        <= bus.a;
            kill_c   <= kill_nxt;
            cnt      <= k;
            bus.busy <= 1'b1;
            if (k == '0) begin
              bus.result    <= bus.a;
              bus.carry_out <= init_c;
              bus.done      <= 1'b1;
              state         <= DONE;
            end else begin
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          w   <= w_nxt;
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            bus.result    <= w_nxt;
            bus.carry_out <= kill_c ? 1'b0 : c_nxt;
            bus.done      <= 1'b1;
            state         <= DONE;
          end
        end
        DONE: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_desplazador_secuencial.sv
// Purpose: self-checking bench for the sequential ARM shifter against an arithmetic reference.
// Latency: checks done arrives exactly k+1 cycles after accept.
// Backpressure: checks start is ignored while busy and a mid-operation reset.
module tb_desplazador_secuencial;

  localparam int N  = 32;
  localparam int AW = 8;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  desplazador_secuencial_if #(.N(N), .AW(AW)) bus ();

  desplazador_secuencial #(.N(N), .AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: ARM shifter semantics computed directly from the full-width amount.
  function automatic void ref_model(input logic [1:0] op, input logic [31:0] a, input int amt,
                                    input logic cin, output logic [31:0] r, output logic c,
                                    output int k);
    logic [63:0] ext;
    logic [63:0] dbl;
    int sh;
    sh = (amt > N) ? N : amt;
    k  = (op == 2'b11) ? (amt % N) : sh;
    r  = a;
    c  = cin;
    if (amt != 0) begin
      case (op)
        2'b00: begin
          if (amt > N) begin r = '0; c = 1'b0; end
          else begin r = 32'(64'(a) << amt); c = a[N - amt]; end
        end
        2'b01: begin
          if (amt > N) begin r = '0; c = 1'b0; end
          else begin r = 32'(64'(a) >> amt); c = a[amt - 1]; end
        end
        2'b10: begin
          ext = {{32{a[31]}}, a};
          r   = ext[sh +: 32];
          c   = a[sh - 1];
        end
        default: begin
          if (k == 0) begin r = a; c = a[31]; end
          else begin
            dbl = {a, a};
            r   = dbl[k +: 32];
            c   = a[k - 1];
          end
        end
      endcase
    end
  endfunction

  // Issue one request when idle, scramble inputs after accept, measure done latency.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [7:0] amt,
                        input logic cin, output logic [31:0] r, output logic c,
                        output int lat, output int busy_drops);
    int guard;
    guard = 0;
    @(negedge clk);
    while (bus.busy && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    bus.start    = 1'b1;
    bus.op       = op;
    bus.a        = a;
    bus.amount   = amt;
    bus.carry_in = cin;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.op       = 2'($urandom_range(0, 3));
    bus.a        = $urandom;
    bus.amount   = 8'($urandom);
    bus.carry_in = ~cin;
    lat        = -1;
    busy_drops = 0;
    for (int n = 1; n <= 300; n++) begin
      if (!bus.busy) busy_drops++;
      if (bus.done) begin
        lat = n;
        break;
      end
      @(negedge clk);
    end
    r = bus.result;
    c = bus.carry_out;
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.op       = 2'b00;
    bus.a        = '0;
    bus.amount   = '0;
    bus.carry_in = 1'b0;
    #1;
    n_cmp += 4;
    if (bus.result !== 32'd0) begin n_bad++; $display("FAIL reset_result got=%h want=0", bus.result); end
    if (bus.carry_out !== 1'b0) begin n_bad++; $display("FAIL reset_carry got=%b want=0", bus.carry_out); end
    if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    if (bus.done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b want=0", bus.done); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [1:0]  ops [10]  = '{2'b11, 2'b00, 2'b00, 2'b10, 2'b00, 2'b01, 2'b10, 2'b11, 2'b11, 2'b01};
    logic [31:0] as  [10]  = '{32'h000000F1, 32'h1, 32'h1, 32'h80000000, 32'h12345678,
                               32'h12345678, 32'h12345678, 32'h12345678, 32'h80000001, 32'h80000000};
    logic [7:0]  ams [10]  = '{8'd4, 8'd32, 8'd33, 8'd200, 8'd0, 8'd0, 8'd0, 8'd0, 8'd64, 8'd32};
    logic        cis [10]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [31:0] wr  [10]  = '{32'h1000000F, 32'h0, 32'h0, 32'hFFFFFFFF, 32'h12345678,
                               32'h12345678, 32'h12345678, 32'h12345678, 32'h80000001, 32'h0};
    logic        wc  [10]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    int          wl  [10]  = '{5, 33, 33, 33, 1, 1, 1, 1, 1, 33};
    logic [31:0] r;
    logic        c;
    int          lat;
    int          drops;
    for (int i = 0; i < 10; i++) begin
      run_op(ops[i], as[i], ams[i], cis[i], r, c, lat, drops);
      n_cmp += 4;
      if (r !== wr[i]) begin n_bad++; $display("FAIL directed_result[%0d] got=%h want=%h", i, r, wr[i]); end
      if (c !== wc[i]) begin n_bad++; $display("FAIL directed_carry[%0d] got=%b want=%b", i, c, wc[i]); end
      if (lat !== wl[i]) begin n_bad++; $display("FAIL directed_latency[%0d] got=%0d want=%0d", i, lat, wl[i]); end
      if (drops !== 0) begin n_bad++; $display("FAIL directed_busy[%0d] low_cycles=%0d want=0", i, drops); end
    end
  endtask

  task automatic test_random();
    logic [1:0]  op;
    logic [31:0] a;
    logic [7:0]  amt;
    logic        cin;
    logic [31:0] r, er;
    logic        c, ec;
    int          lat, drops, k;
    for (int i = 0; i < 60; i++) begin
      op  = 2'($urandom_range(0, 3));
      a   = $urandom;
      cin = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       amt = 8'($urandom_range(0, 8));
        1:       amt = 8'($urandom_range(28, 36));
        2:       amt = 8'($urandom_range(0, 255));
        default: amt = 8'(32 * $urandom_range(0, 7));
      endcase
      ref_model(op, a, int'(amt), cin, er, ec, k);
      run_op(op, a, amt, cin, r, c, lat, drops);
      n_cmp += 3;
      if (r !== er) begin n_bad++; $display("FAIL rand_result op=%0d a=%h amt=%0d got=%h want=%h", op, a, amt, r, er); end
      if (c !== ec) begin n_bad++; $display("FAIL rand_carry op=%0d a=%h amt=%0d got=%b want=%b", op, a, amt, c, ec); end
      if (lat !== k + 1) begin n_bad++; $display("FAIL rand_latency op=%0d amt=%0d got=%0d want=%0d", op, amt, lat, k + 1); end
    end
  endtask

  task automatic test_busy_ignore();
    logic [31:0] a, er;
    logic        ec;
    int          k, lat, dones, guard;
    a = $urandom;
    ref_model(2'b01, a, 10, 1'b1, er, ec, k);
    guard = 0;
    @(negedge clk);
    while (bus.busy && guard < 200) begin @(negedge clk); guard++; end
    bus.start = 1'b1; bus.op = 2'b01; bus.a = a; bus.amount = 8'd10; bus.carry_in = 1'b1;
    @(negedge clk);
    lat   = -1;
    dones = 0;
    for (int n = 1; n <= 30; n++) begin
      if (bus.done) begin
        dones++;
        if (lat < 0) begin
          lat = n;
          n_cmp += 2;
          if (bus.result !== er) begin n_bad++; $display("FAIL busy_ignore_result got=%h want=%h", bus.result, er); end
          if (bus.carry_out !== ec) begin n_bad++; $display("FAIL busy_ignore_carry got=%b want=%b", bus.carry_out, ec); end
        end
      end
      bus.start = (n == 3 || n == 6);
      bus.op    = 2'b00;
      bus.a     = ~a;
      bus.amount = 8'd3;
      @(negedge clk);
    end
    bus.start = 1'b0;
    n_cmp += 3;
    if (lat !== 11) begin n_bad++; $display("FAIL busy_ignore_latency got=%0d want=11", lat); end
    if (dones !== 1) begin n_bad++; $display("FAIL busy_ignore_done_count got=%0d want=1", dones); end
    if (bus.result !== er) begin n_bad++; $display("FAIL busy_ignore_hold got=%h want=%h", bus.result, er); end
  endtask

  task automatic test_reset_midop();
    logic [31:0] a, r, er;
    logic        c, ec;
    int          k, lat, drops, guard;
    guard = 0;
    @(negedge clk);
    while (bus.busy && guard < 200) begin @(negedge clk); guard++; end
    bus.start = 1'b1; bus.op = 2'b00; bus.a = 32'hDEADBEEF; bus.amount = 8'd20; bus.carry_in = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp += 4;
    if (bus.result !== 32'd0) begin n_bad++; $display("FAIL midreset_result got=%h want=0", bus.result); end
    if (bus.carry_out !== 1'b0) begin n_bad++; $display("FAIL midreset_carry got=%b want=0", bus.carry_out); end
    if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL midreset_busy got=%b want=0", bus.busy); end
    if (bus.done !== 1'b0) begin n_bad++; $display("FAIL midreset_done got=%b want=0", bus.done); end
    @(negedge clk);
    rst_n = 1'b1;
    a = $urandom;
    ref_model(2'b10, a, 7, 1'b0, er, ec, k);
    run_op(2'b10, a, 8'd7, 1'b0, r, c, lat, drops);
    n_cmp += 3;
    if (r !== er) begin n_bad++; $display("FAIL midreset_restart_result got=%h want=%h", r, er); end
    if (c !== ec) begin n_bad++; $display("FAIL midreset_restart_carry got=%b want=%b", c, ec); end
    if (lat !== k + 1) begin n_bad++; $display("FAIL midreset_restart_latency got=%0d want=%0d", lat, k + 1); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, r, er;
    logic        c, ec;
    int          k, lat, drops;
    for (int i = 0; i < 4; i++) begin
      a = $urandom;
      ref_model(2'(i), a, i + 1, 1'b0, er, ec, k);
      run_op(2'(i), a, 8'(i + 1), 1'b0, r, c, lat, drops);
      n_cmp += 2;
      if (r !== er) begin n_bad++; $display("FAIL b2b_result[%0d] got=%h want=%h", i, r, er); end
      if (lat !== k + 1) begin n_bad++; $display("FAIL b2b_latency[%0d] got=%0d want=%0d", i, lat, k + 1); end
    end
    @(negedge clk);
    n_cmp += 4;
    if (bus.done !== 1'b0) begin n_bad++; $display("FAIL b2b_done_pulse got=%b want=0", bus.done); end
    if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL b2b_busy_after got=%b want=0", bus.busy); end
    if (bus.result !== er) begin n_bad++; $display("FAIL b2b_result_hold got=%h want=%h", bus.result, er); end
    if (bus.carry_out !== ec) begin n_bad++; $display("FAIL b2b_carry_hold got=%b want=%b", bus.carry_out, ec); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_directed();
    test_random();
    test_busy_ignore();
    test_reset_midop();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
